// File: rtl/ninjakun_scroll.sv
// Background scroll registers: CPU-written X/Y shadows, optionally committed to the
// active values on the VBLANK rising edge, plus the scrolled BG raster coordinates.
module ninjakun_scroll #(
  parameter logic SYNC_COMMIT = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CS_SCRX,
  input  logic       CS_SCRY,
  input  logic       CPWR,
  input  logic       CPRD,
  input  logic [7:0] CPDO,
  input  logic       VBLK,
  input  logic [8:0] HPOS,
  input  logic [8:0] VPOS,
  output logic [7:0] SCR_DO,
  output logic [7:0] SCRX,
  output logic [7:0] SCRY,
  output logic [8:0] BGHP,
  output logic [8:0] BGVP,
  output logic       COMMIT
);

  logic [7:0] shadowX_q, shadowX_d, shadowY_q, shadowY_d;
  logic [7:0] activeX_q, activeX_d, activeY_q, activeY_d;
  logic       pendX_q, pendX_d, pendY_q, pendY_d;
  logic       wrXPrev_q, wrYPrev_q, vblkPrev_q;
  logic [8:0] bghp_q, bghp_d, bgvp_q, bgvp_d;
  logic       commit_q, commit_d;

  logic wrX, wrY, evX, evY, vbEdge;

  // A held strobe yields one event: only its first cycle counts.
  assign wrX    = CS_SCRX & CPWR;
  assign wrY    = CS_SCRY & CPWR;
  assign evX    = wrX & ~wrXPrev_q;
  assign evY    = wrY & ~wrYPrev_q;
  assign vbEdge = VBLK & ~vblkPrev_q;

  always_comb begin
    shadowX_d = shadowX_q;
    shadowY_d = shadowY_q;
    activeX_d = activeX_q;
    activeY_d = activeY_q;
    pendX_d   = pendX_q;
    pendY_d   = pendY_q;
    commit_d  = 1'b0;

    if (evX) shadowX_d = CPDO;
    if (evY) shadowY_d = CPDO;

    if (SYNC_COMMIT) begin
      // Commit copies the pre-write shadow; a coincident write re-arms pending.
      if (vbEdge && pendX_q) begin
        activeX_d = shadowX_q;
        pendX_d   = 1'b0;
      end
      if (vbEdge && pendY_q) begin
        activeY_d = shadowY_q;
        pendY_d   = 1'b0;
      end
      if (evX) pendX_d = 1'b1;
      if (evY) pendY_d = 1'b1;
      commit_d = vbEdge & (pendX_q | pendY_q);
    end else begin
      if (evX) activeX_d = CPDO;
      if (evY) activeY_d = CPDO;
    end

    bghp_d = HPOS + {1'b0, activeX_q};
    bgvp_d = VPOS + {1'b0, activeY_q};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shadowX_q  <= 8'h00;
      shadowY_q  <= 8'h00;
      activeX_q  <= 8'h00;
      activeY_q  <= 8'h00;
      pendX_q    <= 1'b0;
      pendY_q    <= 1'b0;
      wrXPrev_q  <= 1'b0;
      wrYPrev_q  <= 1'b0;
      vblkPrev_q <= 1'b0;
      bghp_q     <= 9'h000;
      bgvp_q     <= 9'h000;
      commit_q   <= 1'b0;
    end else begin
      shadowX_q  <= shadowX_d;
      shadowY_q  <= shadowY_d;
      activeX_q  <= activeX_d;
      activeY_q  <= activeY_d;
      pendX_q    <= pendX_d;
      pendY_q    <= pendY_d;
      wrXPrev_q  <= wrX;
      wrYPrev_q  <= wrY;
      vblkPrev_q <= VBLK;
      bghp_q     <= bghp_d;
      bgvp_q     <= bgvp_d;
      commit_q   <= commit_d;
    end
  end

  assign SCR_DO = (CPRD && CS_SCRX) ? shadowX_q :
                  (CPRD && CS_SCRY) ? shadowY_q : 8'h00;
  assign SCRX   = activeX_q;
  assign SCRY   = activeY_q;
  assign BGHP   = bghp_q;
  assign BGVP   = bgvp_q;
  assign COMMIT = commit_q;

endmodule

// File: tb/tb_ninjakun_scroll.sv
// Scoreboard bench for ninjakun_scroll: one instance with synchronous commit, one
// with immediate writes, both driven by the same directed and random stimulus.
module tb_ninjakun_scroll;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       CS_SCRX, CS_SCRY, CPWR, CPRD, VBLK;
  logic [7:0] CPDO;
  logic [8:0] HPOS, VPOS;

  logic [7:0] doS, scrxS, scryS, doI, scrxI, scryI;
  logic [8:0] bghpS, bgvpS, bghpI, bgvpI;
  logic       commitS, commitI;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  ninjakun_scroll #(.SYNC_COMMIT(1'b1)) dutS (
    .CLK(CLK), .RESET_N(RESET_N), .CS_SCRX(CS_SCRX), .CS_SCRY(CS_SCRY),
    .CPWR(CPWR), .CPRD(CPRD), .CPDO(CPDO), .VBLK(VBLK), .HPOS(HPOS), .VPOS(VPOS),
    .SCR_DO(doS), .SCRX(scrxS), .SCRY(scryS), .BGHP(bghpS), .BGVP(bgvpS),
    .COMMIT(commitS)
  );

  ninjakun_scroll #(.SYNC_COMMIT(1'b0)) dutI (
    .CLK(CLK), .RESET_N(RESET_N), .CS_SCRX(CS_SCRX), .CS_SCRY(CS_SCRY),
    .CPWR(CPWR), .CPRD(CPRD), .CPDO(CPDO), .VBLK(VBLK), .HPOS(HPOS), .VPOS(VPOS),
    .SCR_DO(doI), .SCRX(scrxI), .SCRY(scryI), .BGHP(bghpI), .BGVP(bgvpI),
    .COMMIT(commitI)
  );

  // Reference state: what the register file should hold after each clock edge.
  typedef struct packed {
    logic [7:0] shX, shY, acX, acY;
    logic       pX, pY, strobeX, strobeY, vblk;
    logic [8:0] bgh, bgv;
    logic       commit;
  } model_t;

  model_t mS = '0;
  model_t mI = '0;
  model_t qS[$];
  model_t qI[$];

  function automatic model_t advance(model_t m, bit sync);
    model_t n;
    bit newX, newY, vbRise;
    if (!RESET_N) return '0;
    newX   = CS_SCRX && CPWR && !m.strobeX;
    newY   = CS_SCRY && CPWR && !m.strobeY;
    vbRise = VBLK && !m.vblk;
    n = m;
    n.strobeX = CS_SCRX && CPWR;
    n.strobeY = CS_SCRY && CPWR;
    n.vblk    = VBLK;
    n.bgh     = 9'((int'(HPOS) + int'(m.acX)) % 512);
    n.bgv     = 9'((int'(VPOS) + int'(m.acY)) % 512);
    n.commit  = sync && vbRise && (m.pX || m.pY);
    if (sync) begin
      if (vbRise && m.pX) begin n.acX = m.shX; n.pX = 1'b0; end
      if (vbRise && m.pY) begin n.acY = m.shY; n.pY = 1'b0; end
      if (newX) n.pX = 1'b1;
      if (newY) n.pY = 1'b1;
    end else begin
      if (newX) n.acX = CPDO;
      if (newY) n.acY = CPDO;
    end
    if (newX) n.shX = CPDO;
    if (newY) n.shY = CPDO;
    return n;
  endfunction

  // Expected responses are queued at every rising edge.
  always @(posedge CLK) begin
    mS = advance(mS, 1'b1);
    qS.push_back(mS);
    mI = advance(mI, 1'b0);
    qI.push_back(mI);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic compareEntry(input string tag, input model_t e, input logic [7:0] scrx,
                              input logic [7:0] scry, input logic [7:0] rdData,
                              input logic [8:0] bghp, input logic [8:0] bgvp,
                              input logic commit);
    int expDo;
    expDo = (CPRD && CS_SCRX) ? int'(e.shX) : (CPRD && CS_SCRY) ? int'(e.shY) : 0;
    checkOutput({tag, ".SCRX"},   int'(scrx),   int'(e.acX));
    checkOutput({tag, ".SCRY"},   int'(scry),   int'(e.acY));
    checkOutput({tag, ".BGHP"},   int'(bghp),   int'(e.bgh));
    checkOutput({tag, ".BGVP"},   int'(bgvp),   int'(e.bgv));
    checkOutput({tag, ".COMMIT"}, int'(commit), int'(e.commit));
    checkOutput({tag, ".SCR_DO"}, int'(rdData), expDo);
  endtask

  // Monitor: every falling edge the DUTs present a cycle's outputs to score.
  always @(negedge CLK) begin
    if (qS.size() == 0 || qI.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL queue at %0t: got empty scoreboard, expected an entry", $time);
    end else begin
      compareEntry("sync", qS.pop_front(), scrxS, scryS, doS, bghpS, bgvpS, commitS);
      compareEntry("imm",  qI.pop_front(), scrxI, scryI, doI, bghpI, bgvpI, commitI);
    end
  end

  task automatic applyStimulus(input logic csx, input logic csy, input logic wr,
                               input logic rd, input logic vb, input logic [7:0] d,
                               input int cycles);
    CS_SCRX = csx;
    CS_SCRY = csy;
    CPWR    = wr;
    CPRD    = rd;
    VBLK    = vb;
    CPDO    = d;
    repeat (cycles) begin
      @(negedge CLK);
      #1;
    end
  endtask

  initial begin
    RESET_N = 1'b0;
    HPOS = 9'h000;
    VPOS = 9'h000;
    // Strobe already high across reset release must count once.
    applyStimulus(1, 0, 1, 0, 0, 8'h12, 3);
    RESET_N = 1'b1;
    applyStimulus(1, 0, 1, 0, 0, 8'h12, 2);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 2);
    applyStimulus(0, 0, 0, 0, 1, 8'h00, 2);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 2);

    // Long strobe, read back shadow, commit on VBLANK.
    applyStimulus(1, 0, 1, 0, 0, 8'h5A, 10);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 3);
    applyStimulus(1, 0, 0, 1, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 0, 1, 8'h00, 3);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 2);

    // Coordinate wrap: X=20 over H=1F0, Y=01 over V=0FF.
    applyStimulus(1, 0, 1, 0, 0, 8'h20, 1);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 1);
    applyStimulus(0, 1, 1, 0, 0, 8'h01, 1);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 0, 1, 8'h00, 2);
    HPOS = 9'h1F0;
    VPOS = 9'h0FF;
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 3);

    // Write coinciding with the VBLANK edge while an older Y write is pending.
    applyStimulus(0, 1, 1, 0, 0, 8'h11, 1);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 1);
    applyStimulus(0, 1, 1, 0, 1, 8'h33, 1);
    applyStimulus(0, 1, 0, 1, 1, 8'h00, 2);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 0, 1, 8'h00, 2);

    // VBLANK with nothing pending.
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 0, 1, 8'h00, 2);

    // Immediate-mode readback of a fresh value, then a pending write lost to reset.
    applyStimulus(1, 0, 1, 0, 0, 8'hC3, 1);
    applyStimulus(1, 0, 0, 1, 0, 8'h00, 2);
    applyStimulus(1, 0, 1, 0, 0, 8'h77, 1);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 1);
    RESET_N = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 2);
    RESET_N = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 0, 1, 8'h00, 2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      HPOS = 9'($urandom_range(0, 511));
      VPOS = 9'($urandom_range(0, 511));
      RESET_N = ($urandom_range(0, 199) != 0);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), 8'($urandom), $urandom_range(1, 3));
    end
    RESET_N = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
